// File: rtl/multiplier_seq_fsm.sv
// Control sequencer for the multi-cycle multiplier: pops one FIFO sample, walks the operand
// mux through four partial-product phases, then issues a single rounding/accumulate pulse.
module multiplier_seq_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       PushIn,
  input  logic       PushCoef,
  input  logic       fifo_empty,
  output logic [1:0] multiplier_mux_sel,
  output logic       partialProductAccumulate_valid,
  output logic       finalAccumulateRounding_en,
  output logic       fifoPullOut
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPull  = 3'd1,
    StPp0   = 3'd2,
    StPp1   = 3'd3,
    StPp2   = 3'd4,
    StPp3   = 3'd5,
    StRound = 3'd6
  } state_e;

  state_e state_d, state_q;
  logic   start;

  // Push strobe is status only; it never influences sequencing.
  logic unused_push_in;
  assign unused_push_in = PushIn;

  assign start = !fifo_empty && !PushCoef;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Once a sample is pulled it always runs to ROUND; inputs only matter in IDLE and ROUND.
  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:  state_d = start ? StPull : StIdle;
      StPull:  state_d = StPp0;
      StPp0:   state_d = StPp1;
      StPp1:   state_d = StPp2;
      StPp2:   state_d = StPp3;
      StPp3:   state_d = StRound;
      StRound: state_d = start ? StPull : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    multiplier_mux_sel             = 2'd0;
    partialProductAccumulate_valid = 1'b0;
    finalAccumulateRounding_en     = 1'b0;
    fifoPullOut                    = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StPull:  fifoPullOut = 1'b1;
      StPp0: begin
        multiplier_mux_sel             = 2'd0;
        partialProductAccumulate_valid = 1'b1;
      end
      StPp1: begin
        multiplier_mux_sel             = 2'd1;
        partialProductAccumulate_valid = 1'b1;
      end
      StPp2: begin
        multiplier_mux_sel             = 2'd2;
        partialProductAccumulate_valid = 1'b1;
      end
      StPp3: begin
        multiplier_mux_sel             = 2'd3;
        partialProductAccumulate_valid = 1'b1;
      end
      StRound: finalAccumulateRounding_en = 1'b1;
      default: ;
    endcase
  end

  strobes_exclusive_a: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({fifoPullOut, partialProductAccumulate_valid, finalAccumulateRounding_en}));

  mux_idle_zero_a: assert property (@(posedge clk) disable iff (!reset)
    !partialProductAccumulate_valid |-> (multiplier_mux_sel == 2'd0));

endmodule

// File: tb/tb_multiplier_seq_fsm.sv
// Self-checking bench for multiplier_seq_fsm: vector table, hand-written reset/coef sequences
// and a randomized run against a sample-position reference model.
module tb_multiplier_seq_fsm;

  logic       clk;
  logic       reset;
  logic       PushIn;
  logic       PushCoef;
  logic       fifo_empty;
  logic [1:0] multiplier_mux_sel;
  logic       partialProductAccumulate_valid;
  logic       finalAccumulateRounding_en;
  logic       fifoPullOut;

  multiplier_seq_fsm dut (
    .clk                            (clk),
    .reset                          (reset),
    .PushIn                         (PushIn),
    .PushCoef                       (PushCoef),
    .fifo_empty                     (fifo_empty),
    .multiplier_mux_sel             (multiplier_mux_sel),
    .partialProductAccumulate_valid (partialProductAccumulate_valid),
    .finalAccumulateRounding_en     (finalAccumulateRounding_en),
    .fifoPullOut                    (fifoPullOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fe;
    logic       pc;
    logic       pull;
    logic       valid;
    logic [1:0] mux;
    logic       rnd;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  // Model: position within a sample, -1 idle, 0 pull, 1..4 partial products, 5 round.
  int pos      = -1;
  int pull_cnt = 0;
  int rnd_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int exp_mux;
    int strobes;
    exp_mux = (pos >= 1 && pos <= 4) ? pos - 1 : 0;
    check("pull", int'(fifoPullOut), int'(pos == 0));
    check("valid", int'(partialProductAccumulate_valid), int'(pos >= 1 && pos <= 4));
    check("mux_sel", int'(multiplier_mux_sel), exp_mux);
    check("round", int'(finalAccumulateRounding_en), int'(pos == 5));
    strobes = int'(fifoPullOut) + int'(partialProductAccumulate_valid)
            + int'(finalAccumulateRounding_en);
    check("onehot0", int'(strobes <= 1), 1);
    if (!partialProductAccumulate_valid) check("mux_zero_when_idle", int'(multiplier_mux_sel), 0);
    if (fifoPullOut) pull_cnt++;
    if (finalAccumulateRounding_en) begin
      rnd_cnt++;
      check("pull_round_balance", pull_cnt, rnd_cnt);
    end
  endtask

  // Apply inputs, clock once, advance the model, then sample 1 time unit after the edge.
  task automatic step(input logic fe, input logic pc, input logic pi);
    logic start;
    fifo_empty = fe;
    PushCoef   = pc;
    PushIn     = pi;
    start      = !fe && !pc;
    @(posedge clk);
    if (!reset) pos = -1;
    else if (pos == -1 || pos == 5) pos = start ? 0 : -1;
    else pos = pos + 1;
    #1;
    check_model();
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    #1;
    pos      = -1;
    pull_cnt = 0;
    rnd_cnt  = 0;
    check_model();
  endtask

  vec_t tbl[23];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

    reset      = 1'b1;
    PushIn     = 1'b0;
    PushCoef   = 1'b0;
    fifo_empty = 1'b0;

    // Reset held two cycles with data available: nothing may move.
    #2;
    assert_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    // Release coincides with start: first edge must pull, then PP0..PP3, then round.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    check("post_reset_round", int'(finalAccumulateRounding_en), 1);
    step(1'b1, 1'b0, 1'b0);

    // Vector table: PushCoef gating, PushCoef mid-sample, back-to-back samples.
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].fe, tbl[i].pc, 1'b0);
      check($sformatf("tbl%0d_pull", i), int'(fifoPullOut), int'(tbl[i].pull));
      check($sformatf("tbl%0d_valid", i), int'(partialProductAccumulate_valid),
            int'(tbl[i].valid));
      check($sformatf("tbl%0d_mux", i), int'(multiplier_mux_sel), int'(tbl[i].mux));
      check($sformatf("tbl%0d_round", i), int'(finalAccumulateRounding_en), int'(tbl[i].rnd));
    end

    // Continuous data for 10 cycles then empty: in-flight sample completes, no extra pull.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    check("continuous_drained_idle", pos, -1);

    // Empty FIFO throughout: no pull ever.
    begin
      int pulls_before;
      pulls_before = pull_cnt;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);
      check("empty_no_pull", pull_cnt, pulls_before);
    end

    // Mid-operation reset during PP2 aborts immediately, then a fresh sample starts.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("pp2_before_reset", int'(multiplier_mux_sel), 2);
    assert_reset();
    check("async_reset_valid", int'(partialProductAccumulate_valid), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("fresh_pull", int'(fifoPullOut), 1);
    step(1'b0, 1'b0, 1'b0);
    check("fresh_pp0", int'(partialProductAccumulate_valid), 1);

    // Randomized run with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        #($urandom_range(1, 7));
        assert_reset();
        step(logic'($urandom_range(0, 1)), 1'b0, 1'b0);
        reset = 1'b1;
      end
      step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) == 0),
           logic'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
